ahb_lite_fabric: RTL and testbench
==================================

AHB_LITE_FABRIC -- requirements
Module: ahb_lite_fabric

Interface
REQ-001 SHALL have parameter NUM_SAT, default 3: number of attached AHB-Lite satellites, legal range 1..8.
REQ-002 SHALL have parameter DATA_W, default 32: data width; HADDR is fixed at 32 bits.
REQ-003 SHALL have parameter SAT_BASE, default {32'h4000_2000, 32'h4000_1000, 32'h4000_0000}: flattened NUM_SAT x 32 region base addresses; index i occupies bits [32i+31:32i].
REQ-004 SHALL have parameter SAT_MASK, default {3{32'hFFFF_F000}}: flattened NUM_SAT x 32 compare masks, same packing as SAT_BASE.
REQ-005 SHALL have a single clock and a synchronous, active-high reset.
REQ-006 clk  input  1  system clock; all state updates on its rising edge.
REQ-007 nrst  input  1  synchronous, active-high reset.
REQ-008 haddr/htrans/hwrite/hsize/hwdata  input  32/2/1/3/DATA_W  controller-side address-phase and data-phase signals.
REQ-009 hrdata/hready/hresp  output  DATA_W/1/1  controller-side data-phase response.
REQ-010 s_hsel  output  NUM_SAT  per-satellite select.
REQ-011 s_haddr/s_htrans/s_hwrite/s_hsize/s_hwdata/s_hreadyin  output  32/2/1/3/DATA_W/1  broadcast copies of controller signals; s_hreadyin = hready.
REQ-012 s_hrdata/s_hreadyout/s_hresp  input  NUM_SAT*DATA_W/NUM_SAT/NUM_SAT  per-satellite responses, flattened by index.
REQ-013 err_count  output  16  count of ERROR responses completed.

Function
REQ-014 Decode: satellite i matches when (haddr & SAT_MASK[i]) == (SAT_BASE[i] & SAT_MASK[i]); on overlap, the lowest index wins.
REQ-015 s_hsel SHALL be combinational from haddr: one-hot on a match, all-zero on no match; it is independent of htrans.
REQ-016 Data-phase owner register: loaded when hready=1 (index of the matching satellite, or DEFAULT on no match); held while hready=0.
REQ-017 Response mux: when the owner is satellite i, hrdata/hready/hresp = s_hrdata[i]/s_hreadyout[i]/s_hresp[i] in the same cycle (zero added latency).
REQ-018 Built-in default satellite: states IDLE, ERR1, ERR2.
REQ-019 IDLE: when hready=1 with an unmapped address and htrans = NONSEQ or SEQ -> ERR1; unmapped IDLE/BUSY transfers receive an OKAY, zero-wait response.
REQ-020 ERR1: hready=0, hresp=1 -> ERR2 unconditionally.
REQ-021 ERR2: hready=1, hresp=1 -> IDLE, or -> ERR1 when the next address phase is also an unmapped NONSEQ/SEQ.
REQ-022 While the owner is DEFAULT, hrdata SHALL be 0.
REQ-023 err_count increments by 1 on each cycle with hready=1 and hresp=1, from any owner, and saturates at 16'hFFFF.
REQ-024 Back-to-back transfers to different satellites SHALL be supported with no bubble cycle inserted by the fabric.

Reset
REQ-025 On nrst=1 at a clock edge: owner=DEFAULT, default-satellite state=IDLE, err_count=0.
REQ-026 Outputs during and after reset until the first transfer: hready=1, hresp=0, hrdata=0.
REQ-027 Reset asserted during a stalled data phase SHALL abandon the transfer; no response is completed and err_count is not incremented.

Configuration
REQ-028 Macro AHB_LITE_FABRIC_TIMEOUT_EN: when defined, a 10-bit counter runs while the owner is a satellite and hready=0.
REQ-029 With AHB_LITE_FABRIC_TIMEOUT_EN defined, when the counter reaches 1023 the fabric overrides hready=0, hresp=1 for one cycle, then hready=1, hresp=1 for one cycle, sets owner=DEFAULT, and counts the error once.
REQ-030 With AHB_LITE_FABRIC_TIMEOUT_EN defined, the counter clears on any cycle with hready=1 or when the owner changes.
REQ-031 Without AHB_LITE_FABRIC_TIMEOUT_EN: no counter, and satellites may stall indefinitely.

Verification
REQ-032 Reset, then idle -> hready=1, hresp=0, hrdata=0, err_count=0, s_hsel=0 for an address of 0.
REQ-033 NONSEQ read of 0x4000_1004 with satellite 1 returning 0xDEADBEEF after 2 wait states -> hready low for 2 cycles, then hrdata=0xDEADBEEF, hresp=0.
REQ-034 NONSEQ write to unmapped 0x5000_0000 -> hready=0/hresp=1, then hready=1/hresp=1, err_count=1.
REQ-035 Back-to-back NONSEQ to 0x4000_0000 then 0x4000_2000, both zero-wait -> consecutive data phases muxed from satellites 0 and then 2, no bubble.
REQ-036 Overlapping masks (SAT_MASK[1]=0) with haddr 0x4000_0010 -> s_hsel=3'b001.
REQ-037 With AHB_LITE_FABRIC_TIMEOUT_EN defined and satellite 2 holding s_hreadyout=0 -> two-cycle ERROR response after 1023 stall cycles, err_count increments by 1.

Source files
------------

// File: rtl/ahb_lite_fabric.sv
// rtl/ahb_lite_fabric.sv - AHB-Lite decoder/response mux with default error satellite; optional macro AHB_LITE_FABRIC_TIMEOUT_EN
module ahb_lite_fabric #(
  parameter int                    NUM_SAT  = 3,
  parameter int                    DATA_W   = 32,
  parameter logic [NUM_SAT*32-1:0] SAT_BASE = {32'h4000_2000, 32'h4000_1000, 32'h4000_0000},
  parameter logic [NUM_SAT*32-1:0] SAT_MASK = {3{32'hFFFF_F000}}
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic [31:0]               haddr,
  input  logic [1:0]                htrans,
  input  logic                      hwrite,
  input  logic [2:0]                hsize,
  input  logic [DATA_W-1:0]         hwdata,
  output logic [DATA_W-1:0]         hrdata,
  output logic                      hready,
  output logic                      hresp,
  output logic [NUM_SAT-1:0]        s_hsel,
  output logic [31:0]               s_haddr,
  output logic [1:0]                s_htrans,
  output logic                      s_hwrite,
  output logic [2:0]                s_hsize,
  output logic [DATA_W-1:0]         s_hwdata,
  output logic                      s_hreadyin,
  input  logic [NUM_SAT*DATA_W-1:0] s_hrdata,
  input  logic [NUM_SAT-1:0]        s_hreadyout,
  input  logic [NUM_SAT-1:0]        s_hresp,
  output logic [15:0]               err_count
);

  localparam int IDX_W = (NUM_SAT > 1) ? $clog2(NUM_SAT) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ERR1, ST_ERR2} dstate_t;

  dstate_t          state, state_nxt;
  logic             owner_def, owner_def_nxt;
  logic [IDX_W-1:0] owner_idx, owner_idx_nxt;
  logic [15:0]      err_nxt;
  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic             unmapped_active;
`ifdef AHB_LITE_FABRIC_TIMEOUT_EN
  logic [9:0]       to_cnt, to_nxt;
  logic             to_fire;
`endif

  // Satellite signals are plain broadcasts of the controller side.
  assign s_haddr    = haddr;
  assign s_htrans   = htrans;
  assign s_hwrite   = hwrite;
  assign s_hsize    = hsize;
  assign s_hwdata   = hwdata;
  assign s_hreadyin = hready;

  // Address decode; scanning downward lets the lowest matching index win.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SAT - 1; i >= 0; i--) begin
      if ((haddr & SAT_MASK[32*i +: 32]) == (SAT_BASE[32*i +: 32] & SAT_MASK[32*i +: 32])) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
    s_hsel = hit ? (NUM_SAT'(1) << hit_idx) : '0;
  end

  // Response mux from the data-phase owner, or the default satellite's error sequence.
  always_comb begin
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = '0;
`ifdef AHB_LITE_FABRIC_TIMEOUT_EN
    to_fire = !owner_def && (to_cnt == 10'h3FF);
`endif
    if (!owner_def) begin
      hready = s_hreadyout[owner_idx];
      hresp  = s_hresp[owner_idx];
      hrdata = s_hrdata[owner_idx*DATA_W +: DATA_W];
    end else begin
      case (state)
        ST_ERR1: begin hready = 1'b0; hresp = 1'b1; end
        ST_ERR2: begin hready = 1'b1; hresp = 1'b1; end
        default: ;
      endcase
    end
`ifdef AHB_LITE_FABRIC_TIMEOUT_EN
    // A stuck satellite is cut off with the first half of an ERROR response.
    if (to_fire) begin
      hready = 1'b0;
      hresp  = 1'b1;
    end
`endif
  end

  // Next owner, default-satellite state and error counter.
  always_comb begin
    state_nxt       = state;
    owner_def_nxt   = owner_def;
    owner_idx_nxt   = owner_idx;
    err_nxt         = err_count;
    unmapped_active = hready && !hit && htrans[1];
    if (hready && hresp && (err_count != 16'hFFFF))
      err_nxt = err_count + 16'd1;
    if (hready) begin
      owner_def_nxt = !hit;
      owner_idx_nxt = hit_idx;
    end
    case (state)
      ST_IDLE: if (unmapped_active) state_nxt = ST_ERR1;
      ST_ERR1: state_nxt = ST_ERR2;
      ST_ERR2: state_nxt = unmapped_active ? ST_ERR1 : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
`ifdef AHB_LITE_FABRIC_TIMEOUT_EN
    to_nxt = (hready || owner_def) ? 10'd0 : to_cnt + 10'd1;
    // Second cycle of the timeout error is delivered by the default satellite.
    if (to_fire) begin
      owner_def_nxt = 1'b1;
      state_nxt     = ST_ERR2;
      to_nxt        = 10'd0;
    end
`endif
  end

  // State registers with synchronous reset; reset wins over any pending response.
  always_ff @(posedge clk) begin
    if (nrst) begin
      state     <= ST_IDLE;
      owner_def <= 1'b1;
      owner_idx <= '0;
      err_count <= 16'd0;
`ifdef AHB_LITE_FABRIC_TIMEOUT_EN
      to_cnt    <= 10'd0;
`endif
    end else begin
      state     <= state_nxt;
      owner_def <= owner_def_nxt;
      owner_idx <= owner_idx_nxt;
      err_count <= err_nxt;
`ifdef AHB_LITE_FABRIC_TIMEOUT_EN
      to_cnt    <= to_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_ahb_lite_fabric.sv
// tb/tb_ahb_lite_fabric.sv - randomized and directed self-checking bench for ahb_lite_fabric
module tb_ahb_lite_fabric;
  localparam int NS = 3;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          nrst;
  logic [31:0]   haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [DW-1:0] hwdata;
  logic [DW-1:0] hrdata;
  logic          hready, hresp;
  logic [NS-1:0] s_hsel;
  logic [31:0]   s_haddr;
  logic [1:0]    s_htrans;
  logic          s_hwrite;
  logic [2:0]    s_hsize;
  logic [DW-1:0] s_hwdata;
  logic          s_hreadyin;
  logic [NS*DW-1:0] s_hrdata;
  logic [NS-1:0] s_hreadyout, s_hresp;
  logic [15:0]   err_count;

  logic [DW-1:0] o_hrdata;
  logic          o_hready, o_hresp, o_hwrite, o_hreadyin;
  logic [NS-1:0] o_hsel;
  logic [31:0]   o_haddr;
  logic [1:0]    o_htrans;
  logic [2:0]    o_hsize;
  logic [DW-1:0] o_hwdata;
  logic [15:0]   o_err_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ahb_lite_fabric u_dut (
    .clk(clk), .nrst(nrst), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp),
    .s_hsel(s_hsel), .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hwrite(s_hwrite),
    .s_hsize(s_hsize), .s_hwdata(s_hwdata), .s_hreadyin(s_hreadyin),
    .s_hrdata(s_hrdata), .s_hreadyout(s_hreadyout), .s_hresp(s_hresp),
    .err_count(err_count)
  );

  ahb_lite_fabric #(
    .SAT_MASK({32'hFFFF_F000, 32'h0000_0000, 32'hFFFF_F000})
  ) u_ovl (
    .clk(clk), .nrst(nrst), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hwdata(hwdata), .hrdata(o_hrdata), .hready(o_hready), .hresp(o_hresp),
    .s_hsel(o_hsel), .s_haddr(o_haddr), .s_htrans(o_htrans), .s_hwrite(o_hwrite),
    .s_hsize(o_hsize), .s_hwdata(o_hwdata), .s_hreadyin(o_hreadyin),
    .s_hrdata(s_hrdata), .s_hreadyout(s_hreadyout), .s_hresp(s_hresp),
    .err_count(o_err_count)
  );

  logic [31:0] base_a [NS];
  logic [31:0] mask_a [NS];
  int m_owner = -1;
  int m_err   = 0;
  int m_stall = 0;
  int m_errs  = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int dec(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if ((a & mask_a[i]) == (base_a[i] & mask_a[i])) return i;
    return -1;
  endfunction

  function automatic logic [NS-1:0] exp_sel(input logic [31:0] a);
    int d;
    d = dec(a);
    return (d < 0) ? '0 : (NS'(1) << d);
  endfunction

  task automatic expect_out(output logic r, output logic p, output logic [31:0] d);
    if (m_owner < 0) begin
      d = '0;
      r = (m_err != 2);
      p = (m_err != 0);
    end else begin
      r = s_hreadyout[m_owner];
      p = s_hresp[m_owner];
      d = s_hrdata[m_owner*DW +: DW];
    end
`ifdef AHB_LITE_FABRIC_TIMEOUT_EN
    if (m_owner >= 0 && m_stall == 1023) begin
      r = 1'b0;
      p = 1'b1;
    end
`endif
  endtask

  // Reference model advance: m_err counts remaining error-response cycles of the default satellite.
  always @(posedge clk) begin
    logic r, p;
    logic [31:0] d;
    expect_out(r, p, d);
    if (nrst) begin
      m_owner = -1; m_err = 0; m_stall = 0; m_errs = 0;
    end else begin
      if (r && p && m_errs < 65535) m_errs++;
`ifdef AHB_LITE_FABRIC_TIMEOUT_EN
      if (m_owner >= 0 && m_stall == 1023) begin
        m_owner = -1; m_err = 1; m_stall = 0;
      end else
`endif
      if (m_owner < 0 && m_err == 2) m_err = 1;
      else if (r) begin
        m_owner = dec(haddr);
        m_err   = (m_owner < 0 && htrans[1]) ? 2 : 0;
        m_stall = 0;
      end else if (m_owner >= 0) m_stall++;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic r, p;
    logic [31:0] d;
    expect_out(r, p, d);
    chk("hready", 32'(hready), 32'(r));
    chk("hresp", 32'(hresp), 32'(p));
    chk("hrdata", hrdata, d);
    chk("err_count", 32'(err_count), 32'(m_errs));
    chk("s_hsel", 32'(s_hsel), 32'(exp_sel(haddr)));
    chk("s_hreadyin", 32'(s_hreadyin), 32'(r));
    chk("bcast", {s_haddr ^ s_hwdata}, {haddr ^ hwdata});
    chk("bcast_ctl", 32'({s_htrans, s_hwrite, s_hsize}), 32'({htrans, hwrite, hsize}));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  initial begin
    base_a[0] = 32'h4000_0000; base_a[1] = 32'h4000_1000; base_a[2] = 32'h4000_2000;
    for (int i = 0; i < NS; i++) mask_a[i] = 32'hFFFF_F000;
    nrst = 1'b1; haddr = '0; htrans = 2'd0; hwrite = 1'b0; hsize = 3'd2; hwdata = '0;
    s_hreadyout = '1; s_hresp = '0; s_hrdata = '0;
    repeat (3) step();
    neg();
    chk("rst_hready", 32'(hready), 32'd1);
    chk("rst_hresp", 32'(hresp), 32'd0);
    chk("rst_hrdata", hrdata, 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_s_hsel", 32'(s_hsel), 32'd0);
    step();
    nrst = 1'b0;

    // Read from satellite 1 with two wait states.
    haddr = 32'h4000_1004; htrans = 2'd2;
    step();
    haddr = '0; htrans = 2'd0; s_hreadyout[1] = 1'b0;
    neg(); chk("rd_wait1", 32'(hready), 32'd0);
    step();
    neg(); chk("rd_wait2", 32'(hready), 32'd0);
    step();
    s_hreadyout[1] = 1'b1; s_hrdata[63:32] = 32'hDEAD_BEEF;
    neg();
    chk("rd_ready", 32'(hready), 32'd1);
    chk("rd_data", hrdata, 32'hDEAD_BEEF);
    chk("rd_resp", 32'(hresp), 32'd0);
    step();

    // Unmapped write gets a two-cycle ERROR.
    haddr = 32'h5000_0000; htrans = 2'd2; hwrite = 1'b1;
    step();
    haddr = '0; htrans = 2'd0; hwrite = 1'b0;
    neg(); chk("err1_ready", 32'(hready), 32'd0); chk("err1_resp", 32'(hresp), 32'd1);
    step();
    neg(); chk("err2_ready", 32'(hready), 32'd1); chk("err2_resp", 32'(hresp), 32'd1);
    step();
    neg(); chk("err_cnt1", 32'(err_count), 32'd1); chk("err_done_resp", 32'(hresp), 32'd0);
    step();

    // Back-to-back transfers to satellites 0 then 2.
    s_hrdata = {32'hC2C2_0002, 32'hC1C1_0001, 32'hC0C0_0000};
    haddr = 32'h4000_0000; htrans = 2'd2;
    step();
    haddr = 32'h4000_2000;
    neg(); chk("b2b_d0", hrdata, 32'hC0C0_0000); chk("b2b_r0", 32'(hready), 32'd1);
    step();
    haddr = '0; htrans = 2'd0;
    neg(); chk("b2b_d2", hrdata, 32'hC2C2_0002); chk("b2b_r2", 32'(hready), 32'd1);
    step();

    // Overlapping decode: satellite 1 matches everything, lowest index wins.
    haddr = 32'h4000_0010; #1;
    chk("ovl_sel0", 32'(o_hsel), 32'b001);
    haddr = 32'h4000_2010; #1;
    chk("ovl_sel1", 32'(o_hsel), 32'b010);
    haddr = '0;
    step();

`ifdef AHB_LITE_FABRIC_TIMEOUT_EN
    begin
      int stalls;
      int base;
      base = err_count;
      stalls = 0;
      haddr = 32'h4000_2000; htrans = 2'd2; s_hresp = '0;
      step();
      haddr = '0; htrans = 2'd0; s_hreadyout[2] = 1'b0;
      neg();
      while (hready == 1'b0 && hresp == 1'b0 && stalls < 2000) begin
        stalls++;
        neg();
      end
      chk("to_stalls", 32'(stalls), 32'd1023);
      chk("to_e1", 32'({hready, hresp}), 32'b01);
      neg();
      chk("to_e2", 32'({hready, hresp}), 32'b11);
      neg();
      chk("to_cnt", 32'(err_count), 32'(base + 1));
      s_hreadyout[2] = 1'b1;
      step();
    end
`endif

    // Randomized traffic checked by the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 3))
        0: haddr = base_a[0] | ($urandom & 32'hFFF);
        1: haddr = base_a[1] | ($urandom & 32'hFFF);
        2: haddr = base_a[2] | ($urandom & 32'hFFF);
        default: haddr = $urandom;
      endcase
      htrans = 2'($urandom_range(0, 3));
      hwrite = 1'($urandom_range(0, 1));
      hsize  = 3'($urandom_range(0, 2));
      hwdata = $urandom;
      for (int i = 0; i < NS; i++) begin
        s_hreadyout[i] = ($urandom_range(0, 3) != 0);
        s_hresp[i]     = ($urandom_range(0, 9) == 0);
      end
      s_hrdata = {$urandom, $urandom, $urandom};
      step();
    end

    // Saturation: every cycle completes an ERROR from satellite 0.
    haddr = 32'h4000_0000; htrans = 2'd2; s_hreadyout = '1; s_hresp = '1;
    repeat (65540) step();
    neg();
    chk("sat_err_count", 32'(err_count), 32'hFFFF);
    step();

    // Reset in the middle of a default-satellite error abandons it.
    s_hresp = '0;
    haddr = 32'h5000_0000; htrans = 2'd2;
    step();
    nrst = 1'b1; haddr = '0; htrans = 2'd0;
    step();
    nrst = 1'b0;
    neg();
    chk("rst_abandon_cnt", 32'(err_count), 32'd0);
    chk("rst_abandon_rdy", 32'({hready, hresp}), 32'b10);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
